// File: rtl/rot_amount_finder.sv
`default_nettype none
// ============================================================================
// Module      : rot_amount_finder
// Description : Sequential inverse of the 32-bit rotator. Given a source word
//               and a rotated word, it tests one candidate rotation amount per
//               clock (L_R=1 left, 0 right) and returns the smallest matching
//               amount over a valid/ready handshake.
//               Optional macro ROT_FIND_MASK_EN: adds the match_mask output,
//               disables early exit and reports every matching amount.
// Revision    : 1.0 - initial release
// ============================================================================
module rot_amount_finder #(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] rot,
  input  logic             L_R,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             found,
  output logic [AW-1:0]    amount
`ifdef ROT_FIND_MASK_EN
  ,
  output logic [WIDTH-1:0] match_mask
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [AW-1:0] C_LAST_K = AW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;      // source word rotated by k_q so far
  logic [WIDTH-1:0] rot_q, rot_d;        // latched target word
  logic             lr_q, lr_d;          // latched direction
  logic [AW-1:0]    k_q, k_d;            // candidate amount under test
  logic             found_q, found_d;
  logic [AW-1:0]    amount_q, amount_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             w_match;
  logic [WIDTH-1:0] w_work_rot1;
`ifdef ROT_FIND_MASK_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [AW-1:0]    w_lowest;
`endif

  // Single-step rotation of the work word and candidate comparison
  always_comb begin
    w_match     = (work_q == rot_q);
    w_work_rot1 = lr_q ? {work_q[WIDTH-2:0], work_q[WIDTH-1]}
                       : {work_q[0], work_q[WIDTH-1:1]};
  end

  // Next-state and datapath update for the search FSM
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    rot_d       = rot_q;
    lr_d        = lr_q;
    k_d         = k_q;
    found_d     = found_q;
    amount_d    = amount_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef ROT_FIND_MASK_EN
    mask_d      = mask_q;
    w_lowest    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d     = src;
          rot_d      = rot;
          lr_d       = L_R;
          k_d        = '0;
          found_d    = 1'b0;
          amount_d   = '0;
          in_ready_d = 1'b0;
          state_d    = S_SEARCH;
`ifdef ROT_FIND_MASK_EN
          mask_d     = '0;
`endif
        end
      end
      S_SEARCH: begin
        work_d = w_work_rot1;
        k_d    = k_q + 1'b1;
`ifdef ROT_FIND_MASK_EN
        // Record every match; the result is resolved after the last candidate
        if (w_match) begin
          mask_d = mask_q | (WIDTH'(1) << k_q);
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (mask_d[i]) begin
            w_lowest = AW'(i);
          end
        end
        if (k_q == C_LAST_K) begin
          found_d     = |mask_d;
          amount_d    = w_lowest;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
`else
        // Stop at the first match; the candidate order makes it the smallest
        if (w_match) begin
          found_d     = 1'b1;
          amount_d    = k_q;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (k_q == C_LAST_K) begin
          found_d     = 1'b0;
          amount_d    = '0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      rot_q       <= '0;
      lr_q        <= 1'b0;
      k_q         <= '0;
      found_q     <= 1'b0;
      amount_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ROT_FIND_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      rot_q       <= rot_d;
      lr_q        <= lr_d;
      k_q         <= k_d;
      found_q     <= found_d;
      amount_q    <= amount_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ROT_FIND_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign found      = found_q;
  assign amount     = amount_q;
`ifdef ROT_FIND_MASK_EN
  assign match_mask = mask_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rot_amount_finder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rot_amount_finder
// Description : Randomized self-checking bench for rot_amount_finder against
//               a behavioural rotation-search model. Honours ROT_FIND_MASK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rot_amount_finder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src = '0;
  logic [31:0] rot = '0;
  logic        L_R = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        found;
  logic [4:0]  amount;
`ifdef ROT_FIND_MASK_EN
  logic [31:0] match_mask;
`endif

  int checks = 0;
  int errors = 0;

  rot_amount_finder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src       (src),
    .rot       (rot),
    .L_R       (L_R),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .found     (found),
    .amount    (amount)
`ifdef ROT_FIND_MASK_EN
    ,
    .match_mask(match_mask)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotf(input logic [31:0] s, input int k, input bit left);
    int m;
    m = k % 32;
    if (m == 0) return s;
    if (left) return (s << m) | (s >> (32 - m));
    return (s >> m) | (s << (32 - m));
  endfunction

  // Reference: try every amount, collect matches, pick the smallest
  task automatic model(input logic [31:0] s, input logic [31:0] r, input bit left,
                       output logic [31:0] emask, output logic efound,
                       output logic [4:0] eamt, output int elat);
    emask = '0;
    eamt  = '0;
    for (int k = 31; k >= 0; k--) begin
      if (rotf(s, k, left) == r) begin
        emask[k] = 1'b1;
        eamt     = 5'(k);
      end
    end
    efound = (emask != 0);
`ifdef ROT_FIND_MASK_EN
    elat = 32;
`else
    elat = efound ? int'(eamt) + 1 : 32;
`endif
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_req(input logic [31:0] s, input logic [31:0] r, input bit left, input int hold);
    logic [31:0] emask;
    logic        efound;
    logic [4:0]  eamt;
    int          elat;
    int          n;
    model(s, r, left, emask, efound, eamt, elat);
    wait_ready();
    src = s; rot = r; L_R = left; in_valid = 1'b1;
    @(posedge clk); #1;   // acceptance edge E0
    in_valid = 1'b0;
    src = $urandom; rot = $urandom; L_R = 1'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, elat);
    check("found", 32'(found), 32'(efound));
    check("amount", 32'(amount), 32'(eamt));
`ifdef ROT_FIND_MASK_EN
    check("mask", match_mask, emask);
`endif
    // Backpressure: results hold and new requests are ignored
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; src = $urandom; rot = $urandom;
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_found", 32'(found), 32'(efound));
      check("hold_amount", 32'(amount), 32'(eamt));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] s, r;
    bit          d;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_amount", 32'(amount), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req(32'h0000_0001, 32'h0000_0008, 1'b1, 0);
    run_req(32'h0000_0001, 32'h0000_0008, 1'b0, 5);
    run_req(32'h0000_0001, 32'h0000_0003, 1'b1, 0);
    run_req(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 2);
    run_req(32'h0000_0000, 32'h0000_0000, 1'b0, 0);
    run_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    run_req(32'h8000_0000, 32'h0000_0001, 1'b1, 1);

    // Reset in the middle of a no-match search
    wait_ready();
    src = 32'h0000_0001; rot = 32'h0000_0003; L_R = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_found", 32'(found), 32'd0);
    check("mid_rst_amount", 32'(amount), 32'd0);
`ifdef ROT_FIND_MASK_EN
    check("mid_rst_mask", match_mask, 32'd0);
`endif
    run_req(32'h1234_5678, rotf(32'h1234_5678, 7, 1'b0), 1'b0, 0);

    // Randomized requests: matching rotations, random words, periodic words
    for (int t = 0; t < 30; t++) begin
      d = 1'($urandom);
      case ($urandom_range(0, 2))
        0: begin s = $urandom; r = rotf(s, $urandom_range(0, 31), d); end
        1: begin s = $urandom; r = $urandom; end
        default: begin
          s = {4{8'($urandom)}};
          r = rotf(s, $urandom_range(0, 31), 1'($urandom));
        end
      endcase
      run_req(s, r, d, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
